// File: rtl/mul4_pkg.sv
// Shared types and helpers for the mul4 fitness scorer.
//   state_e     : scorer FSM states
//   LANE_W      : operand/product lane width
//   PROD_W      : full product width
//   LFSR_TAPS   : Fibonacci tap mask (taps 64,63,61,60 -> bits 63,62,60,59)
//   popcount64  : number of set bits in a 64-bit word
package mul4_pkg;

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned PROD_W = 64;

  localparam logic [PROD_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic logic [6:0] popcount64(input logic [PROD_W-1:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mul4_lfsr64.sv
// 64-bit Fibonacci LFSR, shifting left with feedback entering at bit 0.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load_i     : load seed_i (has priority over step_i)
//   seed_i     : value to load; caller guarantees it is non-zero
//   step_i     : advance one step
//   state_o    : current LFSR contents
module mul4_lfsr64
  import mul4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [PROD_W-1:0] seed_i,
  input  logic              step_i,
  output logic [PROD_W-1:0] state_o
);

  logic [PROD_W-1:0] lfsr_q, lfsr_d;
  logic              fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[PROD_W-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Fitness scorer for a combinational 32x32 multiplier candidate. Each vector drives
// pseudo-random operands for one cycle, then compares the candidate product against
// the exact product, accumulating matching bits (score) and fully matching vectors.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start, seed      : begin a run (IDLE/DONE only); seed==0 selects DEFAULT_SEED
//   a1,a0,b1,b0      : registered operands, A={a1,a0}, B={b1,b0}
//   y3,y2,y1,y0      : candidate product {y3,y2,y1,y0}, sampled in SAMPLE only
//   busy, done       : run in progress / run complete (level)
//   score,exact_hits : accumulated results, held in DONE
module mul4_fitness_scorer
  import mul4_pkg::*;
#(
  parameter int unsigned NUM_VECTORS  = 256,
  parameter logic [63:0] DEFAULT_SEED = 64'h9E37_79B9_7F4A_7C15,
  localparam int unsigned SCORE_W     = $clog2(NUM_VECTORS * 64 + 1),
  localparam int unsigned HITS_W      = $clog2(NUM_VECTORS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [63:0]        seed,
  output logic [LANE_W-1:0]  a1,
  output logic [LANE_W-1:0]  a0,
  output logic [LANE_W-1:0]  b1,
  output logic [LANE_W-1:0]  b0,
  input  logic [LANE_W-1:0]  y3,
  input  logic [LANE_W-1:0]  y2,
  input  logic [LANE_W-1:0]  y1,
  input  logic [LANE_W-1:0]  y0,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [HITS_W-1:0]  exact_hits
);

  state_e               state_q, state_d;
  logic [PROD_W-1:0]    opnd_q, opnd_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [HITS_W-1:0]    hits_q, hits_d;
  logic [HITS_W-1:0]    cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 lfsr_load, lfsr_step;
  logic [PROD_W-1:0]    lfsr_state;
  logic [PROD_W-1:0]    seed_eff;
  logic [PROD_W-1:0]    prod_exp;
  logic [PROD_W-1:0]    prod_y;
  logic [6:0]           match_bits;

  // A zero seed would lock the LFSR at zero, so substitute the default.
  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

  mul4_lfsr64 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .seed_i  (seed_eff),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  assign prod_exp   = {32'b0, opnd_q[63:32]} * {32'b0, opnd_q[31:0]};
  assign prod_y     = {y3, y2, y1, y0};
  assign match_bits = popcount64(~(prod_exp ^ prod_y));

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    score_d   = score_q;
    hits_d    = hits_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lfsr_load = 1'b1;
          score_d   = '0;
          hits_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = StDrive;
        end else if (state_q == StDone) begin
          // done/busy are registered off the DONE state, so they switch one
          // cycle after the last SAMPLE (2*NUM_VECTORS+1 cycles after start).
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      StDrive: begin
        opnd_d  = lfsr_state;
        state_d = StSample;
      end
      StSample: begin
        score_d   = score_q + SCORE_W'(match_bits);
        hits_d    = hits_q + HITS_W'(prod_exp == prod_y);
        cnt_d     = cnt_q + 1'b1;
        lfsr_step = 1'b1;
        state_d   = (cnt_q == HITS_W'(NUM_VECTORS - 1)) ? StDone : StDrive;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opnd_q  <= '0;
      score_q <= '0;
      hits_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      score_q <= score_d;
      hits_q  <= hits_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a1         = opnd_q[3*LANE_W +: LANE_W];
  assign a0         = opnd_q[2*LANE_W +: LANE_W];
  assign b1         = opnd_q[1*LANE_W +: LANE_W];
  assign b0         = opnd_q[0 +: LANE_W];
  assign busy       = busy_q;
  assign done       = done_q;
  assign score      = score_q;
  assign exact_hits = hits_q;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Scoreboard bench for mul4_fitness_scorer: runs are issued with an expected result
// pushed into a queue; a monitor pops and compares whenever done rises.
module tb_mul4_fitness_scorer;

  localparam int unsigned NV       = 256;
  localparam logic [63:0] DEF_SEED = 64'h9E37_79B9_7F4A_7C15;
  localparam int unsigned SW       = $clog2(NV * 64 + 1);
  localparam int unsigned HW       = $clog2(NV + 1);

  typedef struct {
    int score;
    int hits;
    int done_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [63:0]   seed;
  logic [15:0]   a1, a0, b1, b0;
  logic [15:0]   y3, y2, y1, y0;
  logic          busy, done;
  logic [SW-1:0] score;
  logic [HW-1:0] hits;

  // Single-vector instance, candidate tied to 15.
  logic          start1;
  logic [63:0]   seed1;
  logic [15:0]   a1_1, a0_1, b1_1, b0_1;
  logic          busy1, done1;
  logic [6:0]    score1;
  logic [0:0]    hits1;

  int            mode;
  logic [63:0]   mask;
  int            cyc   = 0;
  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  bit            prev_done;

  always #5 clk = ~clk;

  // Candidate multiplier behaviours: 0 ideal, 1 inverted, 2 operand-dependent corruption.
  function automatic logic [63:0] cand(input logic [31:0] a, input logic [31:0] b,
                                       input int m, input logic [63:0] mk);
    logic [63:0] e;
    e = {32'b0, a} * {32'b0, b};
    case (m)
      0:       return e;
      1:       return ~e;
      default: return (a[3:0] != 4'd0) ? (e ^ mk) : e;
    endcase
  endfunction

  assign {y3, y2, y1, y0} = cand({a1, a0}, {b1, b0}, mode, mask);

  mul4_fitness_scorer #(.NUM_VECTORS(NV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .a1         (a1),
    .a0         (a0),
    .b1         (b1),
    .b0         (b0),
    .y3         (y3),
    .y2         (y2),
    .y1         (y1),
    .y0         (y0),
    .busy       (busy),
    .done       (done),
    .score      (score),
    .exact_hits (hits)
  );

  mul4_fitness_scorer #(.NUM_VECTORS(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .seed       (seed1),
    .a1         (a1_1),
    .a0         (a0_1),
    .b1         (b1_1),
    .b0         (b0_1),
    .y3         (16'd0),
    .y2         (16'd0),
    .y1         (16'd0),
    .y0         (16'd15),
    .busy       (busy1),
    .done       (done1),
    .score      (score1),
    .exact_hits (hits1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: walk the LFSR sequence and grade every vector directly.
  task automatic model(input logic [63:0] s0, input int m, input logic [63:0] mk,
                       output int sc, output int ht);
    logic [63:0] s, e, y;
    s  = (s0 == 64'd0) ? DEF_SEED : s0;
    sc = 0;
    ht = 0;
    for (int v = 0; v < int'(NV); v++) begin
      e  = {32'b0, s[63:32]} * {32'b0, s[31:0]};
      y  = cand(s[63:32], s[31:0], m, mk);
      sc += $countones(~(e ^ y));
      if (e == y) ht++;
      s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    end
  endtask

  // Issue a run; optionally hold start high through DRIVE and SAMPLE.
  task automatic run(input logic [63:0] s, input int m, input logic [63:0] mk,
                     input bit pulse_mid);
    exp_t e;
    int   sc, ht;
    @(negedge clk);
    mode = m;
    mask = mk;
    model(s, m, mk, sc, ht);
    e.score    = sc;
    e.hits     = ht;
    e.done_cyc = cyc + 2 * int'(NV) + 2;
    sb.push_back(e);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_after_start", 64'(done), 64'd0);
    start = pulse_mid;
    @(negedge clk);
    chk("first_operands", {a1, a0, b1, b0}, (s == 64'd0) ? DEF_SEED : s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 2 * int'(NV) + 20) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_operands"}, {a1, a0, b1, b0}, 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_score"}, 64'(score), 64'd0);
    chk({name, "_hits"}, 64'(hits), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: grade each completed run against the scoreboard head.
  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        if (done && !prev_done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got done=1 want no run pending");
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("run_score", 64'(score), 64'(e.score));
            chk("run_hits", 64'(hits), 64'(e.hits));
            chk("done_latency", 64'(cyc), 64'(e.done_cyc));
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    logic [63:0] s, mk;
    rst_n  = 1'b0;
    start  = 1'b0;
    seed   = 64'd0;
    start1 = 1'b0;
    seed1  = 64'd0;
    mode   = 0;
    mask   = 64'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // Single-vector run: A=3, B=5, candidate says 15.
    seed1  = 64'h0000_0003_0000_0005;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", 64'(busy1), 64'd1);
    @(negedge clk);
    chk("n1_operands", {a1_1, a0_1, b1_1, b0_1}, 64'h0000_0003_0000_0005);
    chk("n1_done_c2", 64'(done1), 64'd0);
    @(negedge clk);
    chk("n1_done_c2b", 64'(done1), 64'd0);
    @(negedge clk);
    chk("n1_done_c3", 64'(done1), 64'd1);
    chk("n1_busy_c3", 64'(busy1), 64'd0);
    chk("n1_score", 64'(score1), 64'd64);
    chk("n1_hits", 64'(hits1), 64'd1);

    // Ideal candidate, default seed, start held through DRIVE and SAMPLE.
    run(64'd0, 0, 64'd0, 1'b1);
    wait_done();
    @(negedge clk);
    chk("done_hold", 64'(done), 64'd1);

    // Restart from DONE with an inverted candidate.
    run({$urandom, $urandom}, 1, 64'd0, 1'b0);
    wait_done();

    for (int i = 0; i < 3; i++) begin
      run({$urandom, $urandom}, 2, {$urandom, $urandom}, 1'b0);
      wait_done();
    end

    // Reset during vector 10 aborts; a fresh run must match an uninterrupted one.
    s  = {$urandom, $urandom};
    mk = {$urandom, $urandom};
    run(s, 2, mk, 1'b0);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(s, 2, mk, 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
